// File: rtl/sort_pkg.sv
// Shared definitions for the serial sorter host bridge, the sorter datapath
// and its controller: default batch geometry and the bridge FSM encoding.
package sort_pkg;

    localparam int SORT_WIDTH   = 32;
    localparam int SORT_N       = 10;
    localparam int SORT_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CAP   = 3'd4,
        ST_HOLD  = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

endpackage

// File: rtl/sort_word_counter.sv
// Saturating up-counter with synchronous clear and enable. The terminal flag
// is high while the count sits one below LIMIT, so an enabled cycle with tc
// set is the one that completes the LIMIT-th event. The count holds at LIMIT
// and never wraps.
module sort_word_counter #(
    parameter int LIMIT = 10,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] MAXV = CW'(LIMIT);

    logic [CW-1:0] cnt;

    // count enabled events, clear has priority, saturate at LIMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAXV)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/sort_stream_bridge.sv
// Host-side bridge to the serial sorter: loads N words from a valid/ready
// stream, starts the sort, waits for done, then unloads the sorted words onto
// a valid/ready output stream with last on the final word.
// Optional feature: define ORDER_CHECK_EN to flag descending output words.
//
// state | meaning
// IDLE  | ready for word 0 of a new batch
// LOAD  | accepting words 1..N-1, each shifted into the sorter
// START | all words loaded; start pulse is issued on the following cycle
// WAIT  | waiting for sorter done, bounded by TIMEOUT
// CAP   | capture sorter head into the output register
// HOLD  | output word valid, waiting for downstream ready
// GAP   | sorter head advancing after an unload pulse
module sort_stream_bridge
    import sort_pkg::*;
#(
    parameter int WIDTH   = SORT_WIDTH,
    parameter int N       = SORT_N,
    parameter int TIMEOUT = SORT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid_i,
    input  logic signed [WIDTH-1:0] s_data_i,
    output logic                    s_ready_o,
    output logic                    m_valid_o,
    output logic signed [WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    input  logic                    m_ready_i,
    output logic signed [WIDTH-1:0] srt_data_o,
    output logic                    srt_load_o,
    output logic                    srt_start_o,
    input  logic                    srt_done_i,
    input  logic signed [WIDTH-1:0] srt_data_i,
    output logic                    srt_unload_o,
    output logic                    busy_o,
    output logic                    timeout_err_o,
    output logic                    order_err_o
);

    state_t state, state_nx;

    logic s_hs;
    logic m_hs;
    logic batch_start;
    logic cnt_clr;
    logic in_tc;
    logic out_tc;
    logic tmo_tc;
    logic tmo_en;

    assign s_hs        = s_ready_o & s_valid_i;
    assign m_hs        = (state == ST_HOLD) & m_valid_o & m_ready_i;
    assign batch_start = (state == ST_IDLE) & s_hs;
    assign cnt_clr     = (state != ST_IDLE) & (state_nx == ST_IDLE);
    assign tmo_en      = (state == ST_WAIT) & ~srt_done_i;

    sort_word_counter #(.LIMIT(N)) u_in_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (s_hs),
        .tc  (in_tc)
    );

    sort_word_counter #(.LIMIT(N)) u_out_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (m_hs),
        .tc  (out_tc)
    );

    sort_word_counter #(.LIMIT(TIMEOUT)) u_tmo_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (tmo_en),
        .tc  (tmo_tc)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state decode; done wins over a same-cycle timeout expiry
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (s_hs) state_nx = ST_LOAD;
            ST_LOAD:  if (s_hs && in_tc) state_nx = ST_START;
            ST_START: state_nx = ST_WAIT;
            ST_WAIT: begin
                if (srt_done_i) begin
                    state_nx = ST_CAP;
                end else if (tmo_tc) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CAP:   state_nx = ST_HOLD;
            ST_HOLD:  if (m_hs) state_nx = out_tc ? ST_IDLE : ST_GAP;
            ST_GAP:   state_nx = ST_CAP;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // registered stream and sorter-side outputs; ready/busy follow next-state
    // so ready drops in the cycle right after the final input handshake, and
    // start is delayed one cycle so it trails the last load pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready_o    <= 1'b0;
            busy_o       <= 1'b0;
            srt_start_o  <= 1'b0;
            srt_load_o   <= 1'b0;
            srt_data_o   <= '0;
            srt_unload_o <= 1'b0;
            m_valid_o    <= 1'b0;
            m_data_o     <= '0;
            m_last_o     <= 1'b0;
        end else begin
            s_ready_o    <= (state_nx == ST_IDLE) || (state_nx == ST_LOAD);
            busy_o       <= (state_nx != ST_IDLE);
            srt_start_o  <= (state == ST_START);
            srt_load_o   <= s_hs;
            srt_unload_o <= m_hs;
            if (s_hs) begin
                srt_data_o <= s_data_i;
            end
            if (state == ST_CAP) begin
                m_data_o  <= srt_data_i;
                m_valid_o <= 1'b1;
                m_last_o  <= out_tc;
            end else if (m_hs) begin
                m_valid_o <= 1'b0;
                m_last_o  <= 1'b0;
            end
        end
    end

    // sticky timeout flag, cleared by the first word of the next batch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err_o <= 1'b0;
        end else if (batch_start) begin
            timeout_err_o <= 1'b0;
        end else if ((state == ST_WAIT) && !srt_done_i && tmo_tc) begin
            timeout_err_o <= 1'b1;
        end
    end

`ifdef ORDER_CHECK_EN
    logic signed [WIDTH-1:0] prev_word;
    logic                    have_prev;

    // flag any accepted output word lower than the one before it in the batch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_err_o <= 1'b0;
            have_prev   <= 1'b0;
            prev_word   <= '0;
        end else if (batch_start) begin
            order_err_o <= 1'b0;
            have_prev   <= 1'b0;
        end else if (m_hs) begin
            if (have_prev && (m_data_o < prev_word)) begin
                order_err_o <= 1'b1;
            end
            prev_word <= m_data_o;
            have_prev <= 1'b1;
        end
    end
`else
    assign order_err_o = 1'b0;
`endif

endmodule
